pattern_sched: RTL
==================

# pattern_sched

Round-robin scheduler that shares one serial pattern generator among `NREQ` requesters. Each requester asks for a frame with a `SELW`-bit selector. The scheduler grants one requester at a time and issues a one-cycle start to the generator. It then watches the generator's valid strobe until the frame completes and returns a per-requester done pulse. A watchdog aborts frames the generator never delivers.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `SELW`, 3: selector width per requester.
- `FRAME_LEN`, 4: generator valid cycles per frame.
- `TIMEOUT`, 8: max cycles from start to frame completion before abort; must be > `FRAME_LEN`+1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  request per requester; level, held until done/err.
- `sel_in`  in  NREQ*SELW  selectors; requester i uses bits [i*SELW +: SELW].
- `gen_valid`  in  1  generator frame-valid strobe.
- `gen_en`  out  1  generator start, one-cycle pulse.
- `gen_sel`  out  SELW  selector to generator, held for the whole grant.
- `grant`  out  NREQ  one-hot owner, held from start until completion.
- `done`  out  NREQ  one-cycle completion pulse to the owner.
- `err`  out  1  one-cycle watchdog abort pulse.
- `busy`  out  1  high in START and WAIT.

## Operation
- States: IDLE, START, WAIT.
- IDLE, any `req` high:
  - Pick the first set bit searching from `ptr` upward, with wrap.
  - Next state START.
  - Register the winner's `sel_in` into `gen_sel`.
  - Set `grant` one-hot.
  - `ptr` <= winner+1 mod NREQ.
- START, one cycle: `gen_en`=1, then go to WAIT.
- WAIT:
  - `vcnt` counts cycles with `gen_valid`=1.
  - On the cycle `gen_valid`=1 with `vcnt`==FRAME_LEN-1, the next edge pulses `done[owner]`, clears `grant`, clears `gen_sel` to 0 and returns to IDLE.
- Watchdog:
  - `wcnt` resets to 0 on entering START and increments every cycle in START/WAIT.
  - When `wcnt`==TIMEOUT-1 and the frame is not completing that cycle, the next edge pulses `err`, clears `grant`, does not pulse `done`, and returns to IDLE.
- `gen_valid` low in WAIT before it is first seen is allowed (generator latency); low gaps after that are also tolerated and only counted cycles matter.
- `gen_valid` high in IDLE is ignored.
- `sel_in` changes after grant are ignored.
- A `req` drop mid-frame is ignored; the frame runs to completion and `done` still pulses.
- A requester still holding `req` after its `done` is re-eligible at lowest priority relative to `ptr`.
- `gen_sel`, `grant`, `done`, `err`, `gen_en` and `busy` are all registered outputs.

## Timing
- Reset values: state IDLE, `ptr`=0, `vcnt`=`wcnt`=0, `gen_en`=0, `gen_sel`=0, `grant`=0, `done`=0, `err`=0, `busy`=0.
- Reset mid-frame clears everything on the next edge; no `done`/`err` is emitted.
- Sequence, with `req` seen at cycle T and the generator registering `en` one cycle into a 4-cycle valid frame:
  - T+1: START, `gen_en`=1, `grant` and `gen_sel` valid.
  - T+2..T+5: `gen_valid`=1.
  - T+6: `done` pulse, `grant`=0, IDLE.
  - T+7: next START at earliest.
- Request-to-start latency is 1 cycle; minimum frame period is 6 cycles.
- Simultaneous requests: exactly one is granted per arbitration.
- `ptr` wrap: after requester NREQ-1, priority returns to 0.
- `done` and `err` are mutually exclusive. If completion and timeout fall on the same cycle, completion wins.
- `gen_en` never asserts outside START.

## Test plan
- Single request: `req`=0001, `sel_in[2:0]`=3'b101, generator gives 4 valid cycles.
  - Expect `gen_en` at T+1, `gen_sel`=101, `grant`=0001 for T+1..T+5, `done`=0001 at T+6.
- All requesting: `req`=1111 held for 4 frames.
  - Expect grant order 0001, 0010, 0100, 1000, then 0001 again.
  - Expect one `done` per frame and frame starts every 6 cycles.
- Fairness after wrap: after granting 1000, set `req`=1001.
  - Expect 0001 granted next, then 1000.
- Stalled generator: `gen_valid` stuck at 0 after grant.
  - Expect `err` pulse 8 cycles after START, no `done`, `grant`=0, IDLE.
  - A pending request is then granted normally.
- Mid-frame changes: drop `req` and change `sel_in` at T+3.
  - Expect `gen_sel` unchanged and `done` still at T+6.
- Mid-frame reset: assert `rst` at T+3 for 1 cycle.
  - Expect all outputs 0 next cycle, `ptr`=0, no `done`.
  - Next request from 0010/0001 grants 0001 first.

Source files
------------

// File: rtl/pattern_sched.sv
// pattern_sched: round-robin scheduler sharing one serial pattern generator
// among NREQ requesters. A grant issues a one-cycle start to the generator,
// counts its valid strobes until the frame completes and then returns a
// done pulse to the owner. A watchdog aborts frames that never complete.
module pattern_sched #(
    parameter int NREQ      = 4,
    parameter int SELW      = 3,
    parameter int FRAME_LEN = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SELW-1:0] sel_in,
    input  logic                 gen_valid,
    output logic                 gen_en,
    output logic [SELW-1:0]      gen_sel,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int VW = $clog2(FRAME_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [PW:0]   NREQ_W = (PW + 1)'(NREQ);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
    localparam logic [VW-1:0] VLAST = VW'(FRAME_LEN - 1);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [VW-1:0]   vcnt;
    logic [WW-1:0]   wcnt;

    logic [NREQ-1:0] rot;
    logic            found;
    logic [PW:0]     offs;
    logic [PW:0]     sum;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] win_onehot;
    logic [SELW-1:0] win_sel;
    logic            frame_last;

    assign frame_last = gen_valid && (vcnt == VLAST);

    // Round-robin pick: rotate requests so ptr sits at bit 0, take the first set bit, then map back.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        found = 1'b0;
        offs  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                offs  = (PW + 1)'(k);
            end
        end
        sum      = {1'b0, ptr} + offs;
        win      = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : PW'(sum);
        ptr_next = (win == PTR_LAST) ? '0 : win + 1'b1;
    end

    // Decode the winner into its one-hot grant and its selector slice.
    always_comb begin
        win_onehot = '0;
        win_sel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_onehot[i] = 1'b1;
                win_sel       = sel_in[i*SELW +: SELW];
            end
        end
    end

    // Scheduler FSM: arbitrate in IDLE, pulse the start, then count valid strobes against the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            vcnt    <= '0;
            wcnt    <= '0;
            gen_en  <= 1'b0;
            gen_sel <= '0;
            grant   <= '0;
            done    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            gen_en <= 1'b0;
            done   <= '0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    vcnt <= '0;
                    wcnt <= '0;
                    if (found) begin
                        state   <= START;
                        gen_en  <= 1'b1;
                        busy    <= 1'b1;
                        gen_sel <= win_sel;
                        grant   <= win_onehot;
                        ptr     <= ptr_next;
                    end
                end
                START: begin
                    state <= WAIT;
                    wcnt  <= wcnt + 1'b1;
                end
                WAIT: begin
                    if (frame_last) begin
                        done    <= grant;
                        grant   <= '0;
                        gen_sel <= '0;
                        busy    <= 1'b0;
                        vcnt    <= '0;
                        wcnt    <= '0;
                        state   <= IDLE;
                    end else if (wcnt == WLAST) begin
                        err     <= 1'b1;
                        grant   <= '0;
                        gen_sel <= '0;
                        busy    <= 1'b0;
                        vcnt    <= '0;
                        wcnt    <= '0;
                        state   <= IDLE;
                    end else begin
                        if (gen_valid) begin
                            vcnt <= vcnt + 1'b1;
                        end
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
